// File: rtl/log_mel_compress.sv
// log_mel_compress: mel energy -> signed fixed-point log2 (MSB + linear mantissa), framed for the DCT
// Ports: clk, rst_n (sync, active-low)
//   mel_valid_i/mel_idx_i/mel_energy_i/mel_ready_o : one unsigned energy per filter in
//   out_valid_o/frame_ptr_o/power_o                : log value written into the DCT input buffer
//   dct_start_o / dct_done_i                       : frame handshake with the DCT
//   drop_o                                         : sticky, some input was discarded
module log_mel_compress #(
  parameter int NUM_FILTERS  = 40,
  parameter int ENERGY_WIDTH = 32,
  parameter int FRAC_BITS    = 3,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LOG_OFFSET   = 128,
  parameter int NF_LOG2      = $clog2(NUM_FILTERS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mel_valid_i,
  input  logic [NF_LOG2-1:0]      mel_idx_i,
  input  logic [ENERGY_WIDTH-1:0] mel_energy_i,
  output logic                    mel_ready_o,
  input  logic                    dct_done_i,
  output logic                    out_valid_o,
  output logic [NF_LOG2-1:0]      frame_ptr_o,
  output logic [OUTPUT_WIDTH-1:0] power_o,
  output logic                    dct_start_o,
  output logic                    drop_o
);
  localparam int MW = $clog2(ENERGY_WIDTH);
  localparam int CW = MW + FRAC_BITS;
  localparam int AW = (CW > OUTPUT_WIDTH ? CW : OUTPUT_WIDTH) + 2;
  localparam logic signed [AW-1:0] OFF  = AW'(LOG_OFFSET);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (OUTPUT_WIDTH-1)) - 1);
  localparam logic signed [AW-1:0] MINV = AW'(-(1 << (OUTPUT_WIDTH-1)));
  localparam logic [NF_LOG2:0] NFV = (NF_LOG2+1)'(NUM_FILTERS);

  typedef enum logic [1:0] {COLLECT, FLUSH, WAIT_DCT} state_t;
  state_t state, state_d;

  logic [NF_LOG2-1:0]      cnt;
  logic                    acc, last, busy;
  logic                    v1, v2;
  logic [ENERGY_WIDTH-1:0] e1;
  logic [NF_LOG2-1:0]      i1, i2;
  logic [MW-1:0]           msb, msb2;
  logic [FRAC_BITS-1:0]    mant, mant2;
  logic signed [AW-1:0]    diff;
  logic [OUTPUT_WIDTH-1:0] power_d;

  assign acc  = mel_valid_i && mel_ready_o && ({1'b0, mel_idx_i} < NFV);
  assign last = cnt == NF_LOG2'(NUM_FILTERS - 1);
  assign busy = v1 || v2 || out_valid_o;

  always_comb begin
    mel_ready_o = state == COLLECT;
    dct_start_o = state == FLUSH && !busy;
    state_d     = (state == COLLECT && acc && last) ? FLUSH :
                  dct_start_o                      ? WAIT_DCT :
                  (state == WAIT_DCT && dct_done_i) ? COLLECT : state;
  end

  always_ff @(posedge clk)
    if (!rst_n) state <= COLLECT;
    else        state <= state_d;

  // Energy 0 leaves msb at 0 and mant at 0, which is exactly the code of energy 1.
  always_comb begin
    msb = '0;
    for (int i = 1; i < ENERGY_WIDTH; i++)
      if (e1[i]) msb = MW'(i);
  end

  // Bits just below the MSB, with zeros shifted in when fewer than FRAC_BITS exist.
  assign mant = FRAC_BITS'({e1, {FRAC_BITS{1'b0}}} >> msb);

  assign diff    = $signed({{(AW-CW){1'b0}}, msb2, mant2}) - OFF;
  assign power_d = diff > MAXV ? MAXV[OUTPUT_WIDTH-1:0] :
                   diff < MINV ? MINV[OUTPUT_WIDTH-1:0] : diff[OUTPUT_WIDTH-1:0];

  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt         <= '0;
      drop_o      <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      e1          <= '0;
      i1          <= '0;
      msb2        <= '0;
      mant2       <= '0;
      i2          <= '0;
      frame_ptr_o <= '0;
      power_o     <= '0;
    end else begin
      cnt         <= acc ? (last ? '0 : cnt + 1'b1) : cnt;
      drop_o      <= drop_o || (mel_valid_i && !acc);
      v1          <= acc;
      e1          <= mel_energy_i;
      i1          <= mel_idx_i;
      v2          <= v1;
      msb2        <= msb;
      mant2       <= mant;
      i2          <= i1;
      out_valid_o <= v2;
      frame_ptr_o <= i2;
      power_o     <= power_d;
    end
endmodule

// File: tb/tb_log_mel_compress.sv
// tb_log_mel_compress: table vectors, hand sequences and random traffic against a cycle-level reference model
module tb_log_mel_compress;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mel_valid_i;
  logic [5:0]  mel_idx_i;
  logic [31:0] mel_energy_i;
  logic        mel_ready_o;
  logic        dct_done_i;
  logic        out_valid_o;
  logic [5:0]  frame_ptr_o;
  logic [7:0]  power_o;
  logic        dct_start_o;
  logic        drop_o;

  log_mel_compress dut (
    .clk(clk), .rst_n(rst_n),
    .mel_valid_i(mel_valid_i), .mel_idx_i(mel_idx_i), .mel_energy_i(mel_energy_i),
    .mel_ready_o(mel_ready_o), .dct_done_i(dct_done_i),
    .out_valid_o(out_valid_o), .frame_ptr_o(frame_ptr_o), .power_o(power_o),
    .dct_start_o(dct_start_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: log2 approximated as floor(log2 e) + linear fraction of the next octave.
  function automatic logic [7:0] ref_pw(input logic [31:0] e);
    longint v, m, frac, code;
    v = (e == 0) ? 1 : longint'(e);
    m = 0;
    while ((v >> (m + 1)) != 0) m++;
    frac = ((v * 8) >> m) - 8;
    code = m * 8 + frac - 128;
    if (code > 127) code = 127;
    if (code < -128) code = -128;
    return 8'(code);
  endfunction

  typedef struct {int due; int idx; logic [7:0] pw;} exp_t;
  exp_t exp_q[$];
  int  c = 0;
  bit  model_ok = 0;
  bit  open_m;
  int  cnt_m;
  int  start_due;
  bit  drop_m;

  always @(negedge clk) begin
    bit ov;
    c++;
    if (model_ok) begin
      chk("ready", 32'(mel_ready_o), 32'(open_m));
      ov = exp_q.size() > 0 && exp_q[0].due == c;
      chk("out_valid", 32'(out_valid_o), 32'(ov));
      if (ov) begin
        chk("power", 32'(power_o), 32'(exp_q[0].pw));
        chk("frame_ptr", 32'(frame_ptr_o), 32'(exp_q[0].idx));
        void'(exp_q.pop_front());
      end
      chk("dct_start", 32'(dct_start_o), 32'(c == start_due));
      chk("drop", 32'(drop_o), 32'(drop_m));
    end
    if (!rst_n) begin
      exp_q.delete();
      open_m = 1; cnt_m = 0; start_due = -1; drop_m = 0; model_ok = 1;
    end else if (model_ok) begin
      if (mel_valid_i) begin
        if (open_m && int'(mel_idx_i) < 40) begin
          exp_q.push_back('{c + 3, int'(mel_idx_i), ref_pw(mel_energy_i)});
          cnt_m++;
          if (cnt_m == 40) begin
            open_m = 0; cnt_m = 0; start_due = c + 4;
          end
        end else drop_m = 1;
      end
      if (dct_done_i && !open_m && start_due >= 0 && c > start_due) open_m = 1;
    end
  end

  task automatic cyc_in(input bit v, input int idx, input logic [31:0] e, input bit done);
    mel_valid_i = v; mel_idx_i = 6'(idx); mel_energy_i = e; dct_done_i = done;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc_in(0, 0, 0, 0);
    cyc_in(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_e();
    return ($urandom % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
  endfunction

  task automatic wait_start(input int lim, output int n);
    n = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (dct_start_o && n < 0) n = k;
      @(posedge clk); #1;
      if (n >= 0) break;
    end
  endtask

  task automatic run_frame(input bit gaps, input bit bad);
    int k, n;
    bit bad_done;
    k = 0; bad_done = 0;
    while (k < 40) begin
      if (bad && !bad_done && k == 20) begin
        cyc_in(1, 45, rnd_e(), 0);
        bad_done = 1;
        @(negedge clk);
        chk("bad_idx_drop", 32'(drop_o), 1);
        @(posedge clk); #1;
      end else if (gaps && $urandom % 3 == 0) cyc_in(0, 0, 0, $urandom % 5 == 0);
      else begin
        cyc_in(1, k, rnd_e(), 0);
        k++;
      end
    end
    cyc_in(0, 0, 0, 0);
    wait_start(20, n);
    chk("frame_start_lat", 32'(n), 2);
    cyc_in(0, 0, 0, 1);
    @(negedge clk);
    chk("ready_after_done", 32'(mel_ready_o), 1);
    @(posedge clk); #1;
  endtask

  typedef struct {logic [31:0] e; int idx; logic [7:0] pw;} vec_t;
  vec_t tbl[9];

  initial begin
    int n;
    tbl[0] = '{32'h0000_0000, 0, 8'h80};
    tbl[1] = '{32'h0000_0001, 1, 8'h80};
    tbl[2] = '{32'h0000_0100, 2, 8'hC0};
    tbl[3] = '{32'h0000_0180, 3, 8'hC4};
    tbl[4] = '{32'h8000_0000, 4, 8'h78};
    tbl[5] = '{32'hFFFF_FFFF, 5, 8'h7F};
    tbl[6] = '{32'h0000_0002, 6, 8'h88};
    tbl[7] = '{32'h0000_0003, 7, 8'h8C};
    tbl[8] = '{32'h0001_0000, 8, 8'h00};

    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_o), 0);
    chk("rst_start", 32'(dct_start_o), 0);
    chk("rst_drop", 32'(drop_o), 0);
    chk("rst_ready", 32'(mel_ready_o), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      cyc_in(1, tbl[i].idx, tbl[i].e, 0);
      cyc_in(0, 0, 0, 0);
      cyc_in(0, 0, 0, 0);
      @(negedge clk);
      chk("tbl_valid", 32'(out_valid_o), 1);
      chk("tbl_power", 32'(power_o), 32'(tbl[i].pw));
      chk("tbl_ptr", 32'(frame_ptr_o), 32'(tbl[i].idx));
      @(posedge clk); #1;
    end

    cyc_in(1, 9, 32'h1234, 0);
    cyc_in(0, 0, 0, 0);
    do_reset();

    for (int k = 0; k < 40; k++) cyc_in(1, k, rnd_e(), 0);
    mel_valid_i = 0;
    @(negedge clk);
    chk("full_ready_low", 32'(mel_ready_o), 0);
    @(posedge clk); #1;
    wait_start(10, n);
    chk("full_start_lat", 32'(n), 2);

    repeat (5) cyc_in(1, $urandom % 40, rnd_e(), 0);
    mel_valid_i = 0;
    @(negedge clk);
    chk("bp_drop", 32'(drop_o), 1);
    @(posedge clk); #1;
    cyc_in(0, 0, 0, 1);
    @(negedge clk);
    chk("bp_ready", 32'(mel_ready_o), 1);
    @(posedge clk); #1;

    run_frame(0, 0);
    run_frame(1, 0);
    do_reset();
    run_frame(0, 1);

    repeat (800)
      cyc_in($urandom % 2 == 0, ($urandom % 10 == 0) ? int'($urandom_range(40, 63)) : int'($urandom % 40),
             rnd_e(), $urandom % 6 == 0);
    repeat (10) cyc_in(0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
